// File: rtl/mp_add_sequencer_pkg.sv
// Shared constants for the byte-serial multi-precision adder/subtractor.
package mp_add_sequencer_pkg;

  localparam int BYTE_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_FIN  = ST_FIN
  } state_e;

endpackage

// File: rtl/mp_add_sequencer_gcla8_adder.sv
// 8-bit adder built from two 4-bit lookahead groups joined by a second
// lookahead level; exports block generate/propagate for the outer carry chain.
module gcla8_adder
  import mp_add_sequencer_pkg::*;
(
  input  logic [BYTE_W-1:0] A,
  input  logic [BYTE_W-1:0] B,
  input  logic              CIN,
  output logic [BYTE_W-1:0] S,
  output logic              G,
  output logic              P
);

  logic [BYTE_W-1:0] g, p, c;
  logic [1:0]        gg, pp;
  logic              cg1;

  assign g = A & B;
  assign p = A ^ B;

  // Level 1: flat carry equations inside each 4-bit group.
  always_comb begin
    c = '0;
    gg = '0;
    pp = '0;
    cg1 = 1'b0;
    for (int j = 0; j < 2; j++) begin
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      pp[j] = &p[4*j +: 4];
    end
    // Level 2: carry into the upper group straight from group G/P.
    cg1 = gg[0] | (pp[0] & CIN);
    for (int j = 0; j < 2; j++) begin
      logic ci;
      ci = (j == 0) ? CIN : cg1;
      c[4*j]   = ci;
      c[4*j+1] = g[4*j] | (p[4*j] & ci);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & ci);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & ci);
    end
  end

  assign S = p ^ c;
  assign G = gg[1] | (pp[1] & gg[0]);
  assign P = pp[1] & pp[0];

endmodule

// File: rtl/mp_add_sequencer.sv
// Byte-serial W-bit add/subtract controller: one shared 8-bit adder walked
// LSB-first over the latched operands, carry registered between bytes.
module mp_add_sequencer
  import mp_add_sequencer_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     START,
  input  logic                     SUB,
  input  logic                     CIN,
  input  logic [BYTE_W*NBYTES-1:0] A,
  input  logic [BYTE_W*NBYTES-1:0] B,
  output logic [BYTE_W*NBYTES-1:0] S,
  output logic                     COUT,
  output logic                     OVF,
  output logic                     BUSY,
  output logic                     DONE
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

  state_e             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       s_q, s_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [BYTE_W-1:0]  byte_a, byte_b, byte_s;
  logic               blk_g, blk_p;

  // Byte select by decode so every slice index stays a constant.
  always_comb begin
    byte_a = '0;
    byte_b = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        byte_a = a_q[BYTE_W*i +: BYTE_W];
        byte_b = b_q[BYTE_W*i +: BYTE_W];
      end
    end
  end

  gcla8_adder u_add (
    .A   (byte_a),
    .B   (byte_b),
    .CIN (carry_q),
    .S   (byte_s),
    .G   (blk_g),
    .P   (blk_p)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          // Subtract is A + ~B + 1; B is stored already inverted.
          a_d     = A;
          b_d     = B ^ {W{SUB}};
          carry_d = SUB ? 1'b1 : CIN;
          idx_d   = '0;
          s_d     = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int i = 0; i < NBYTES; i++) begin
          if (idx_q == IDX_W'(i)) s_d[BYTE_W*i +: BYTE_W] = byte_s;
        end
        carry_d = blk_g | (blk_p & carry_q);
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          cout_d  = carry_d;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (byte_s[BYTE_W-1] != a_q[W-1]);
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign S    = s_q;
  assign COUT = cout_q;
  assign OVF  = ovf_q;
  assign BUSY = (state_q == S_RUN);
  assign DONE = (state_q == S_FIN);

endmodule
